// File: rtl/bcd_converter_if.sv
// Handshake and result bundle for bcd_converter.
//   start/bin          : conversion request and binary operand (master -> slave)
//   busy/done/overflow : status, done is a one-cycle pulse (slave -> master)
//   digit0..digit3     : held BCD result, digit0 = ones (slave -> master)
interface bcd_converter_if #(
   parameter int unsigned BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [3:0]       digit0;
   logic [3:0]       digit1;
   logic [3:0]       digit2;
   logic [3:0]       digit3;

   modport master (
      output start, bin,
      input  busy, done, overflow, digit0, digit1, digit2, digit3
   );

   modport slave (
      input  start, bin,
      output busy, done, overflow, digit0, digit1, digit2, digit3
   );
endinterface

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Operands above 9999 saturate to 9999 and raise overflow.
//   sysclk : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : bcd_converter_if slave (start/bin in; busy/done/overflow/digits out)
module bcd_converter #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic           sysclk,
   input  logic           rst,
   bcd_converter_if.slave bus
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] SAT = BIN_W'(9999);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } state_t;

   state_t           state;
   logic [BIN_W-1:0] op;
   logic [BCD_W-1:0] bcd;
   logic [CNT_W-1:0] cnt;
   logic             ovf_next;
   logic             busy_q;
   logic             done_q;
   logic             overflow_q;
   logic [BCD_W-1:0] digits_q;

   logic [BCD_W-1:0]       bcd_adj_c;
   logic [BCD_W+BIN_W-1:0] shift_c;

   // Add-3 correction on every nibble that is 5 or more before the shift
   always_comb begin
      bcd_adj_c = bcd;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Operand MSB moves into the BCD LSB
   assign shift_c = {bcd_adj_c, op} << 1;

   // Control FSM with registered outputs
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state      <= IDLE;
         op         <= '0;
         bcd        <= '0;
         cnt        <= '0;
         ovf_next   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         digits_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op       <= (bus.bin > SAT) ? SAT : bus.bin;
                  ovf_next <= (bus.bin > SAT);
                  bcd      <= '0;
                  cnt      <= '0;
                  busy_q   <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               bcd <= shift_c[BCD_W+BIN_W-1:BIN_W];
               op  <= shift_c[BIN_W-1:0];
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               digits_q   <= bcd;
               overflow_q <= ovf_next;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
   assign bus.digit0   = digits_q[3:0];
   assign bus.digit1   = digits_q[7:4];
   assign bus.digit2   = digits_q[11:8];
   assign bus.digit3   = digits_q[15:12];
endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: vector table, corner-case sequences
// and a randomized sweep against a decimal reference model.
module tb_bcd_converter;
   logic sysclk = 1'b0;
   logic rst    = 1'b1;
   int   tests  = 0;
   int   fails  = 0;

   logic [15:0] last_exp = 16'h0000;
   logic        last_ovf = 1'b0;

   bcd_converter_if #(.BIN_W(14)) bus ();

   bcd_converter #(.BIN_W(14), .DIGITS(4)) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int          bin;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [15:0] ref_bcd(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   function automatic logic [15:0] cur_digits();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One conversion from idle; optional extra start pulse sampled at edge E<poke_at>
   task automatic run_conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                           input int poke_at, input int poke_v);
      int done_at, pulses, busy_cnt;
      bit stable_ok;
      done_at = -1; pulses = 0; busy_cnt = 0; stable_ok = 1'b1;
      bus.start = 1'b1;
      bus.bin   = 14'(v);
      for (int k = 0; k < 20; k++) begin
         @(posedge sysclk);
         @(negedge sysclk);
         if (k == 0) begin
            bus.start = 1'b0;
            bus.bin   = 14'($urandom);
         end
         if (k == poke_at - 1) begin
            bus.start = 1'b1;
            bus.bin   = 14'(poke_v);
         end else if (k == poke_at) begin
            bus.start = 1'b0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            pulses++;
            if (done_at < 0) done_at = k;
         end
         if (done_at < 0 && (cur_digits() != last_exp || bus.overflow != last_ovf))
            stable_ok = 1'b0;
      end
      check($sformatf("done_edge bin=%0d", v), done_at, 15);
      check($sformatf("done_pulses bin=%0d", v), pulses, 1);
      check($sformatf("busy_cycles bin=%0d", v), busy_cnt, 15);
      check($sformatf("held_stable bin=%0d", v), int'(stable_ok), 1);
      check($sformatf("digits bin=%0d", v), int'(cur_digits()), int'(exp_bcd));
      check($sformatf("overflow bin=%0d", v), int'(bus.overflow), int'(exp_ovf));
      last_exp = exp_bcd;
      last_ovf = exp_ovf;
   endtask

   initial begin
      int pulses, busy_seen, n;
      int edges[4];
      vecs[0] = '{0,     16'h0000, 1'b0};
      vecs[1] = '{1234,  16'h1234, 1'b0};
      vecs[2] = '{9999,  16'h9999, 1'b0};
      vecs[3] = '{10,    16'h0010, 1'b0};
      vecs[4] = '{12000, 16'h9999, 1'b1};
      vecs[5] = '{42,    16'h0042, 1'b0};
      edges = '{9998, 9999, 10000, 16383};

      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check("reset_outputs",
            int'({bus.busy, bus.done, bus.overflow, cur_digits()}), 0);
      rst = 1'b0;
      @(negedge sysclk);

      // Vector table
      foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf, 0, 0);

      // Start during conversion is ignored
      run_conv(5678, 16'h5678, 1'b0, 5, 1111);

      // Reset mid-conversion, sampled at E7
      bus.start = 1'b1;
      bus.bin   = 14'd8765;
      pulses = 0;
      for (int k = 0; k < 26; k++) begin
         @(posedge sysclk);
         @(negedge sysclk);
         if (k == 0) bus.start = 1'b0;
         if (k == 6) rst = 1'b1;
         if (k == 7) begin
            check("mid_reset_outputs",
                  int'({bus.busy, bus.done, bus.overflow, cur_digits()}), 0);
            rst = 1'b0;
         end
         if (k > 7 && (bus.done || bus.busy)) pulses++;
      end
      check("mid_reset_no_activity", pulses, 0);
      last_exp = 16'h0000;
      last_ovf = 1'b0;
      run_conv(8765, 16'h8765, 1'b0, 0, 0);

      // Reset on the same edge as start
      rst = 1'b1;
      bus.start = 1'b1;
      bus.bin = 14'd1234;
      @(posedge sysclk);
      @(negedge sysclk);
      rst = 1'b0;
      bus.start = 1'b0;
      busy_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge sysclk);
         @(negedge sysclk);
         if (bus.busy || bus.done) busy_seen++;
      end
      check("reset_beats_start", busy_seen, 0);
      check("reset_beats_start_digits", int'(cur_digits()), 0);
      last_exp = 16'h0000;
      last_ovf = 1'b0;

      // Start held high, operand alternating 1/2 per accept
      bus.start = 1'b1;
      bus.bin   = 14'd1;
      for (int k = 0; k < 64; k++) begin
         @(posedge sysclk);
         @(negedge sysclk);
         n = k / 16;
         if (k % 16 == 0) bus.bin = ((n + 1) % 2 == 0) ? 14'd1 : 14'd2;
         if (k == 63) bus.start = 1'b0;
         check($sformatf("stream_done k=%0d", k), int'(bus.done), int'(k % 16 == 15));
         if (k % 16 == 15) last_exp = ref_bcd((n % 2 == 0) ? 1 : 2);
         check($sformatf("stream_digits k=%0d", k), int'(cur_digits()), int'(last_exp));
      end
      @(negedge sysclk);
      check("stream_stops", int'(bus.busy), 0);

      // Boundary operands and randomized sweep against the decimal model
      foreach (edges[i]) run_conv(edges[i], ref_bcd(edges[i]), edges[i] > 9999, 0, 0);
      for (int i = 0; i < 250; i++) begin
         int v;
         v = int'($urandom_range(0, 16383));
         run_conv(v, ref_bcd(v), v > 9999, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
